// File: rtl/drv_pwr_seq_pkg.sv
// rtl/drv_pwr_seq_pkg.sv - shared defaults and per-drive state encoding for the drive power sequencer
package drv_pwr_seq_pkg;

    localparam logic [17:0] STAGGER_CYC_DEF     = 18'd250000;
    localparam logic [17:0] PG_TIMEOUT_CYC_DEF  = 18'd250000;
    localparam logic [7:0]  PG_DEBOUNCE_CYC_DEF = 8'd100;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RAMP  = 3'd2,
        ST_ON    = 3'd3,
        ST_FAULT = 3'd4
    } drv_state_e;

endpackage

// File: rtl/drv_pwr_fsm.sv
// rtl/drv_pwr_fsm.sv - one drive's power FSM with RAMP timeout timer and power-good debounce
module drv_pwr_fsm
    import drv_pwr_seq_pkg::*;
#(
    parameter logic [17:0] PG_TIMEOUT_CYC  = PG_TIMEOUT_CYC_DEF,
    parameter logic [7:0]  PG_DEBOUNCE_CYC = PG_DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic pg,
    input  logic present,
    input  logic grant,
    input  logic fault_clr,
    output logic req,
    output logic en,
    output logic ok,
    output logic fault
);

    drv_state_e  state;
    drv_state_e  state_nxt;
    logic [17:0] timer;
    logic [7:0]  deb_cnt;

    // Withdrawal beats faults, faults beat progress.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF: begin
                if (go) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!go)        state_nxt = ST_OFF;
                else if (grant) state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (!go)                                    state_nxt = ST_OFF;
                else if (timer == PG_TIMEOUT_CYC - 18'd1)   state_nxt = ST_FAULT;
                else if (pg && deb_cnt == PG_DEBOUNCE_CYC)  state_nxt = ST_ON;
            end
            ST_ON: begin
                if (!go)      state_nxt = ST_OFF;
                else if (!pg) state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                if (!present || fault_clr) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    assign req = (state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_OFF;
            timer   <= '0;
            deb_cnt <= '0;
            en      <= 1'b0;
            ok      <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state <= state_nxt;
            en    <= (state_nxt == ST_RAMP) || (state_nxt == ST_ON);
            ok    <= (state_nxt == ST_ON);
            fault <= (state_nxt == ST_FAULT);
            if (state != ST_RAMP) begin
                timer   <= '0;
                deb_cnt <= '0;
            end else begin
                if (timer != '1) timer <= timer + 18'd1;
                // deb_cnt holds the number of consecutive high samples seen so far
                if (!pg)                                deb_cnt <= '0;
                else if (deb_cnt != PG_DEBOUNCE_CYC)    deb_cnt <= deb_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/drv_pwr_seq.sv
// rtl/drv_pwr_seq.sv - staggered per-drive power sequencer: input synchronizers, grant arbiter, per-drive FSMs
module drv_pwr_seq
    import drv_pwr_seq_pkg::*;
#(
    parameter int          NUM_DRV         = 24,
    parameter logic [17:0] STAGGER_CYC     = STAGGER_CYC_DEF,
    parameter logic [17:0] PG_TIMEOUT_CYC  = PG_TIMEOUT_CYC_DEF,
    parameter logic [7:0]  PG_DEBOUNCE_CYC = PG_DEBOUNCE_CYC_DEF
) (
    input  logic               SYSCLK,
    input  logic               RESET_N,
    input  logic               PWR_EN_REQ,
    input  logic [NUM_DRV-1:0] DRV_PRSNT_L,
    input  logic [NUM_DRV-1:0] DRV_PG,
    input  logic               FAULT_CLR,
    output logic [NUM_DRV-1:0] DRV_PWR_EN,
    output logic [NUM_DRV-1:0] DRV_PWROK,
    output logic [NUM_DRV-1:0] DRV_FAULT
);

    logic [NUM_DRV-1:0] prsnt_l_meta;
    logic [NUM_DRV-1:0] prsnt_l_sync;
    logic [NUM_DRV-1:0] pg_meta;
    logic [NUM_DRV-1:0] pg_sync;
    logic [NUM_DRV-1:0] present;
    logic [NUM_DRV-1:0] go;
    logic [NUM_DRV-1:0] req;
    logic [NUM_DRV-1:0] grant;
    logic [17:0]        gap_cnt;

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prsnt_l_meta <= '0;
            prsnt_l_sync <= '0;
            pg_meta      <= '0;
            pg_sync      <= '0;
        end else begin
            prsnt_l_meta <= DRV_PRSNT_L;
            prsnt_l_sync <= prsnt_l_meta;
            pg_meta      <= DRV_PG;
            pg_sync      <= pg_meta;
        end
    end

    assign present = ~prsnt_l_sync;
    assign go      = present & {NUM_DRV{PWR_EN_REQ}};

    // Lowest-index requester wins; the gap counter enforces inrush spacing.
    assign grant = (gap_cnt == '0) ? (req & (~req + NUM_DRV'(1))) : '0;

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N)             gap_cnt <= '0;
        else if (|grant)          gap_cnt <= STAGGER_CYC - 18'd1;
        else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 18'd1;
    end

    for (genvar i = 0; i < NUM_DRV; i++) begin : g_drv
        drv_pwr_fsm #(
            .PG_TIMEOUT_CYC (PG_TIMEOUT_CYC),
            .PG_DEBOUNCE_CYC(PG_DEBOUNCE_CYC)
        ) u_fsm (
            .clk      (SYSCLK),
            .rst_n    (RESET_N),
            .go       (go[i]),
            .pg       (pg_sync[i]),
            .present  (present[i]),
            .grant    (grant[i]),
            .fault_clr(FAULT_CLR),
            .req      (req[i]),
            .en       (DRV_PWR_EN[i]),
            .ok       (DRV_PWROK[i]),
            .fault    (DRV_FAULT[i])
        );
    end

endmodule

// File: tb/tb_drv_pwr_seq.sv
// tb/tb_drv_pwr_seq.sv - self-checking bench for drv_pwr_seq with a timestamp-based reference model
module tb_drv_pwr_seq;

    localparam int N   = 4;
    localparam int STAG = 8;
    localparam int TO   = 32;
    localparam int DEB  = 4;
    localparam int M_OFF = 0, M_WAIT = 1, M_RAMP = 2, M_ON = 3, M_FAULT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] prs_l = '1;
    logic [N-1:0] pg = '0;
    logic [N-1:0] en, ok, fault;

    int n_chk = 0;
    int n_pass = 0;
    int tick = 0;
    bit pg_auto = 1'b0;
    int en_age[N];

    drv_pwr_seq #(
        .NUM_DRV(N), .STAGGER_CYC(18'd8), .PG_TIMEOUT_CYC(18'd32), .PG_DEBOUNCE_CYC(8'd4)
    ) dut (
        .SYSCLK(clk), .RESET_N(rst_n), .PWR_EN_REQ(req), .DRV_PRSNT_L(prs_l), .DRV_PG(pg),
        .FAULT_CLR(clr), .DRV_PWR_EN(en), .DRV_PWROK(ok), .DRV_FAULT(fault)
    );

    always #5 clk = ~clk;

    // Reference model: pins are seen two ticks late, RAMP age and stagger come from tick stamps.
    int           mode[N];
    int           ramp_t0[N];
    int           pg_run[N];
    int           last_grant;
    logic [N-1:0] prs_h1, prs_h2, pg_h1, pg_h2;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mode[i] = M_OFF;
            ramp_t0[i] = 0;
            pg_run[i] = 0;
        end
        last_grant = -1000;
        prs_h1 = '0; prs_h2 = '0; pg_h1 = '0; pg_h2 = '0;
    endtask

    task automatic model_tick();
        logic [N-1:0] prs, pgs;
        int gi;
        logic g;
        prs = ~prs_h2;
        pgs = pg_h2;
        gi = -1;
        if (tick - last_grant >= STAG)
            for (int i = N - 1; i >= 0; i--) if (mode[i] == M_WAIT) gi = i;
        if (gi >= 0) last_grant = tick;
        for (int i = 0; i < N; i++) begin
            g = req && prs[i];
            case (mode[i])
                M_OFF:  if (g) mode[i] = M_WAIT;
                M_WAIT: begin
                    if (!g) mode[i] = M_OFF;
                    else if (i == gi) begin
                        mode[i] = M_RAMP; ramp_t0[i] = tick; pg_run[i] = 0;
                    end
                end
                M_RAMP: begin
                    pg_run[i] = pgs[i] ? pg_run[i] + 1 : 0;
                    if (!g)                         mode[i] = M_OFF;
                    else if (tick - ramp_t0[i] >= TO) mode[i] = M_FAULT;
                    else if (pg_run[i] > DEB)       mode[i] = M_ON;
                end
                M_ON: begin
                    if (!g)           mode[i] = M_OFF;
                    else if (!pgs[i]) mode[i] = M_FAULT;
                end
                default: if (!prs[i] || clr) mode[i] = M_OFF;
            endcase
        end
        prs_h2 = prs_h1; prs_h1 = prs_l;
        pg_h2 = pg_h1;   pg_h1 = pg;
    endtask

    function automatic logic [3*N-1:0] model_out();
        logic [N-1:0] e, o, f;
        e = '0; o = '0; f = '0;
        for (int i = 0; i < N; i++) begin
            e[i] = (mode[i] == M_RAMP) || (mode[i] == M_ON);
            o[i] = (mode[i] == M_ON);
            f[i] = (mode[i] == M_FAULT);
        end
        return {e, o, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (tick %0d)", name, act, exp, tick);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            tick++;
            if (!rst_n) model_reset();
            else        model_tick();
            chk("model", {20'd0, en, ok, fault}, {20'd0, model_out()});
            for (int i = 0; i < N; i++) begin
                en_age[i] = en[i] ? en_age[i] + 1 : 0;
                if (pg_auto) pg[i] = (en_age[i] >= 6);
            end
        end
    endtask

    typedef struct {
        int           n;
        logic         rq;
        logic [N-1:0] pl;
        logic [N-1:0] pgv;
        logic         cl;
        logic [N-1:0] e_en;
        logic [N-1:0] e_ok;
        logic [N-1:0] e_f;
    } vec_t;

    vec_t tbl[11];
    int en_rise[N], ok_rise[N], pg_rise[N];
    int t0;

    initial begin
        tbl[0]  = '{5,  1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{60, 1'b1, 4'h0, 4'hF, 1'b0, 4'hF, 4'hF, 4'h0};
        tbl[2]  = '{1,  1'b0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{80, 1'b1, 4'h0, 4'hB, 1'b0, 4'hB, 4'hB, 4'h4};
        tbl[4]  = '{1,  1'b1, 4'h0, 4'hB, 1'b1, 4'hB, 4'hB, 4'h0};
        tbl[5]  = '{20, 1'b1, 4'h0, 4'hF, 1'b0, 4'hF, 4'hF, 4'h0};
        tbl[6]  = '{5,  1'b1, 4'h0, 4'h7, 1'b0, 4'h7, 4'h7, 4'h8};
        tbl[7]  = '{3,  1'b0, 4'h0, 4'h7, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[8]  = '{30, 1'b1, 4'h8, 4'h7, 1'b0, 4'h7, 4'h7, 4'h0};
        tbl[9]  = '{20, 1'b1, 4'h0, 4'hF, 1'b0, 4'hF, 4'hF, 4'h0};
        tbl[10] = '{3,  1'b0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < N; i++) en_age[i] = 0;
        model_reset();

        step(3);
        chk("reset_outputs", {20'd0, en, ok, fault}, 32'd0);
        rst_n = 1'b1;

        for (int r = 0; r < 11; r++) begin
            req = tbl[r].rq; prs_l = tbl[r].pl; pg = tbl[r].pgv; clr = tbl[r].cl;
            step(tbl[r].n);
            clr = 1'b0;
            chk("tbl_en", en, tbl[r].e_en);
            chk("tbl_ok", ok, tbl[r].e_ok);
            chk("tbl_fault", fault, tbl[r].e_f);
        end

        // staggered bring-up, PG following EN
        pg = '0; step(3);
        for (int i = 0; i < N; i++) begin en_rise[i] = -1; ok_rise[i] = -1; pg_rise[i] = -1; end
        pg_auto = 1'b1; req = 1'b1;
        for (int k = 0; k < 200 && ok != 4'hF; k++) begin
            step(1);
            for (int i = 0; i < N; i++) begin
                if (en[i] && en_rise[i] < 0) en_rise[i] = tick;
                if (ok[i] && ok_rise[i] < 0) ok_rise[i] = tick;
                if (pg[i] && pg_rise[i] < 0) pg_rise[i] = tick;
            end
        end
        chk("bringup_all_ok", ok, 4'hF);
        for (int i = 1; i < N; i++) chk("stagger_gap", en_rise[i] - en_rise[i-1], STAG);
        for (int i = 0; i < N; i++) chk("ok_latency", ok_rise[i] - pg_rise[i], 2 + DEB + 1);

        // one-sample PG drop while ON
        pg_auto = 1'b0;
        pg[1] = 1'b0; step(1); pg[1] = 1'b1; step(1);
        chk("drop_still_on", en[1], 1);
        step(1);
        chk("drop_fault", {en[1], ok[1], fault[1]}, 3'b001);

        // glitch during RAMP restarts the debounce
        pg[1] = 1'b0; clr = 1'b1; step(1); clr = 1'b0;
        for (int k = 0; k < 20 && !en[1]; k++) step(1);
        chk("retry_en", en[1], 1);
        pg[1] = 1'b1; step(2); pg[1] = 1'b0; step(1); pg[1] = 1'b1; t0 = tick;
        for (int k = 0; k < 30 && !ok[1]; k++) step(1);
        chk("glitch_restart", tick - t0, 2 + DEB + 1);

        // withdrawal with drives in ON, RAMP and WAIT
        req = 1'b0; step(2);
        pg = '1; req = 1'b1;
        for (int k = 0; k < 40 && !en[1]; k++) step(1);
        step(2);
        chk("withdraw_pre", {ok[0], en[1], ok[1], en[3:2]}, 5'b11000);
        req = 1'b0; step(1);
        chk("withdraw_off", {20'd0, en, ok, fault}, 32'd0);

        // async reset mid-ramp
        pg = '0; req = 1'b1;
        for (int k = 0; k < 40 && !en[0]; k++) step(1);
        step(2);
        chk("ramp_before_reset", {en[0], ok[0]}, 2'b10);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", {20'd0, en, ok, fault}, 32'd0);
        model_reset();
        step(2);
        rst_n = 1'b1; pg = '1;
        for (int k = 0; k < 80 && ok != 4'hF; k++) step(1);
        chk("restart_all_ok", ok, 4'hF);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(19) == 0) req = ~req;
            if ($urandom_range(29) == 0) begin
                int d;
                d = $urandom_range(N - 1);
                prs_l[d] = ~prs_l[d];
            end
            clr = ($urandom_range(24) == 0);
            for (int i = 0; i < N; i++) pg[i] = en[i] && ($urandom_range(39) != 0);
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
